// File: rtl/prog_loader_pkg.sv
// Shared definitions for the boot-time program loader: FSM encoding and sizing.
package prog_loader_pkg;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LEN   = 3'd1,
        S_DATA  = 3'd2,
        S_WRITE = 3'd3,
        S_CSUM  = 3'd4,
        S_DONE  = 3'd5,
        S_ERR   = 3'd6
    } state_t;

    localparam logic [7:0] SYNC_BYTE_DEF = 8'hA5;
    localparam int         MAX_LEN_DEF   = 32;
    localparam int         ADDR_W        = 5;

endpackage

// File: rtl/prog_loader_csum8.sv
// 8-bit modular checksum accumulator; carry out of the sum is discarded.
module csum8 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       clr,
    input  logic       add_en,
    input  logic [7:0] data,
    output logic [7:0] sum
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            sum <= '0;
        else if (clr)
            sum <= '0;
        else if (add_en)
            sum <= sum + data;
    end

endmodule

// File: rtl/prog_loader.sv
// Byte-stream program loader: receives SYNC/LEN/DATA/CSUM frames, writes program
// memory one byte per two cycles and holds the CPU in reset until a frame verifies.
module prog_loader
    import prog_loader_pkg::*;
#(
    parameter logic [7:0] SYNC_BYTE = SYNC_BYTE_DEF,
    parameter int         MAX_LEN   = MAX_LEN_DEF
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              rx_valid_i,
    input  logic [7:0]        rx_data_i,
    output logic              rx_ready_o,
    output logic              pm_we_o,
    output logic [ADDR_W-1:0] pm_addr_o,
    output logic [7:0]        pm_data_o,
    output logic              cpu_rst_o,
    output logic              busy_o,
    output logic              done_o,
    output logic              err_o
);

    localparam logic [7:0] MAX_LEN_B = 8'(MAX_LEN);

    state_t            state, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [7:0]        len_q, len_d;
    logic [7:0]        data_q, data_d;
    logic              cpu_rst_q, cpu_rst_d;
    logic              done_q, done_d;
    logic              err_q, err_d;
    logic              acc;
    logic              is_sync;
    logic              csum_clr;
    logic              csum_add;
    logic [7:0]        sum;

    assign rx_ready_o = (state != S_WRITE);
    assign acc        = rx_valid_i && rx_ready_o;
    assign is_sync    = (rx_data_i == SYNC_BYTE);
    assign pm_we_o    = (state == S_WRITE);
    assign pm_addr_o  = addr_q;
    assign pm_data_o  = data_q;
    assign cpu_rst_o  = cpu_rst_q;
    assign done_o     = done_q;
    assign err_o      = err_q;
    assign busy_o     = (state == S_LEN) || (state == S_DATA) ||
                        (state == S_WRITE) || (state == S_CSUM);

    csum8 u_csum (
        .clk    (clk_i),
        .rst_n  (rst_i),
        .clr    (csum_clr),
        .add_en (csum_add),
        .data   (rx_data_i),
        .sum    (sum)
    );

    always_comb begin
        state_d   = state;
        addr_d    = addr_q;
        len_d     = len_q;
        data_d    = data_q;
        cpu_rst_d = cpu_rst_q;
        done_d    = done_q;
        err_d     = err_q;
        csum_clr  = 1'b0;
        csum_add  = 1'b0;
        case (state)
            S_IDLE, S_DONE, S_ERR: begin
                if (acc && is_sync) begin
                    state_d   = S_LEN;
                    cpu_rst_d = 1'b1;
                    done_d    = 1'b0;
                    err_d     = 1'b0;
                end
            end
            S_LEN: begin
                if (acc) begin
                    if (rx_data_i == 8'd0 || rx_data_i > MAX_LEN_B) begin
                        state_d   = S_ERR;
                        err_d     = 1'b1;
                        cpu_rst_d = 1'b1;
                    end else begin
                        state_d  = S_DATA;
                        len_d    = rx_data_i;
                        addr_d   = '0;
                        csum_clr = 1'b1;
                    end
                end
            end
            S_DATA: begin
                if (acc) begin
                    data_d   = rx_data_i;
                    csum_add = 1'b1;
                    state_d  = S_WRITE;
                end
            end
            S_WRITE: begin
                // The last write leaves the address at LEN-1 so a full frame never wraps.
                if (8'(addr_q) + 8'd1 < len_q) begin
                    addr_d  = addr_q + 1'b1;
                    state_d = S_DATA;
                end else begin
                    state_d = S_CSUM;
                end
            end
            S_CSUM: begin
                if (acc) begin
                    if (rx_data_i == sum) begin
                        state_d   = S_DONE;
                        done_d    = 1'b1;
                        cpu_rst_d = 1'b0;
                    end else begin
                        state_d   = S_ERR;
                        err_d     = 1'b1;
                        cpu_rst_d = 1'b1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state     <= S_IDLE;
            addr_q    <= '0;
            len_q     <= '0;
            data_q    <= '0;
            cpu_rst_q <= 1'b1;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state     <= state_d;
            addr_q    <= addr_d;
            len_q     <= len_d;
            data_q    <= data_d;
            cpu_rst_q <= cpu_rst_d;
            done_q    <= done_d;
            err_q     <= err_d;
        end
    end

endmodule

// File: tb/tb_prog_loader.sv
// Directed self-checking bench for prog_loader; memory writes are logged on the falling edge.
module tb_prog_loader;

    logic       clk_i = 1'b0;
    logic       rst_i = 1'b0;
    logic       rx_valid_i = 1'b0;
    logic [7:0] rx_data_i = '0;
    logic       rx_ready_o, pm_we_o, cpu_rst_o, busy_o, done_o, err_o;
    logic [4:0] pm_addr_o;
    logic [7:0] pm_data_o;

    int n_pass = 0;
    int n_total = 0;
    logic [12:0] wlog[$];
    logic we_prev = 1'b0;
    logic dbl_we = 1'b0;
    logic gaps = 1'b0;

    prog_loader dut (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .rx_valid_i (rx_valid_i),
        .rx_data_i  (rx_data_i),
        .rx_ready_o (rx_ready_o),
        .pm_we_o    (pm_we_o),
        .pm_addr_o  (pm_addr_o),
        .pm_data_o  (pm_data_o),
        .cpu_rst_o  (cpu_rst_o),
        .busy_o     (busy_o),
        .done_o     (done_o),
        .err_o      (err_o)
    );

    always #5 clk_i = ~clk_i;

    always @(negedge clk_i) begin
        if (pm_we_o) wlog.push_back({pm_addr_o, pm_data_o});
        if (pm_we_o && we_prev) dbl_we = 1'b1;
        we_prev = pm_we_o;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Called at a falling edge; returns at the falling edge after the byte is taken.
    task automatic send(input logic [7:0] b);
        int n = 0;
        if (gaps) begin
            rx_valid_i = 1'b0;
            repeat ($urandom_range(0, 3)) @(negedge clk_i);
        end
        rx_valid_i = 1'b1;
        rx_data_i  = b;
        while (!rx_ready_o && n < 20) begin
            @(negedge clk_i);
            n++;
        end
        if (n >= 20) check("rx_ready_timeout", 32'd1, 32'd0);
        @(negedge clk_i);
        rx_valid_i = 1'b0;
    endtask

    task automatic check_log(input string tag, input int idx, input logic [4:0] a, input logic [7:0] d);
        if (idx < wlog.size()) check(tag, 32'(wlog[idx]), 32'({a, d}));
        else check(tag, 32'hDEAD, 32'({a, d}));
    endtask

    initial begin
        repeat (2) @(negedge clk_i);
        rst_i = 1'b1;
        @(negedge clk_i);

        check("rst_cpu_rst", 32'(cpu_rst_o), 32'd1);
        check("rst_we", 32'(pm_we_o), 32'd0);
        check("rst_addr", 32'(pm_addr_o), 32'd0);
        check("rst_data", 32'(pm_data_o), 32'd0);
        check("rst_status", 32'({busy_o, done_o, err_o}), 32'd0);
        check("rst_ready", 32'(rx_ready_o), 32'd1);

        // Good 3-byte frame, with a stall after LEN
        wlog.delete();
        send(8'hA5);
        check("a_busy_len", 32'({busy_o, cpu_rst_o}), 32'b11);
        send(8'h03);
        repeat (5) @(negedge clk_i);
        check("a_stall", 32'({busy_o, pm_we_o, pm_addr_o, 8'(wlog.size())}), 32'({1'b1, 1'b0, 5'd0, 8'd0}));
        send(8'h11); send(8'h22); send(8'h33); send(8'h66);
        check("a_nwrites", 32'(wlog.size()), 32'd3);
        check_log("a_w0", 0, 5'd0, 8'h11);
        check_log("a_w1", 1, 5'd1, 8'h22);
        check_log("a_w2", 2, 5'd2, 8'h33);
        check("a_status", 32'({busy_o, done_o, err_o, cpu_rst_o}), 32'b0100);

        // Restart from DONE, bad checksum (sum 30, sent 31)
        wlog.delete();
        send(8'hA5);
        check("b_restart", 32'({busy_o, done_o, cpu_rst_o}), 32'b101);
        send(8'h02); send(8'h10); send(8'h20); send(8'h31);
        check("b_nwrites", 32'(wlog.size()), 32'd2);
        check_log("b_w0", 0, 5'd0, 8'h10);
        check_log("b_w1", 1, 5'd1, 8'h20);
        check("b_status", 32'({busy_o, done_o, err_o, cpu_rst_o}), 32'b0011);

        // Illegal lengths
        wlog.delete();
        send(8'hA5); send(8'h00);
        check("len0_status", 32'({busy_o, done_o, err_o, cpu_rst_o}), 32'b0011);
        send(8'hA5); send(8'h21);
        check("len33_status", 32'({busy_o, done_o, err_o, cpu_rst_o}), 32'b0011);
        check("badlen_nwrites", 32'(wlog.size()), 32'd0);

        // Junk ignored, SYNC value as data and as checksum
        wlog.delete();
        send(8'h00); send(8'hFF);
        check("junk_ignored", 32'({busy_o, err_o}), 32'b01);
        send(8'hA5); send(8'h01); send(8'hA5); send(8'hA5);
        check("sync_data_nwrites", 32'(wlog.size()), 32'd1);
        check_log("sync_data_w0", 0, 5'd0, 8'hA5);
        check("sync_data_status", 32'({busy_o, done_o, err_o, cpu_rst_o}), 32'b0100);

        // Full-length frame with random valid gaps
        wlog.delete();
        gaps = 1'b1;
        send(8'hA5); send(8'h20);
        for (int i = 0; i < 32; i++) send(8'(i));
        send(8'hF0);
        gaps = 1'b0;
        check("full_nwrites", 32'(wlog.size()), 32'd32);
        for (int i = 0; i < 32; i++) check_log($sformatf("full_w%0d", i), i, 5'(i), 8'(i));
        check("full_status", 32'({busy_o, done_o, err_o, cpu_rst_o}), 32'b0100);

        // Reset mid-frame, then a normal load
        send(8'hA5); send(8'h05); send(8'h01); send(8'h02); send(8'h03);
        rst_i = 1'b0;
        #1;
        check("mid_rst_out", 32'({busy_o, done_o, err_o, cpu_rst_o, pm_we_o}), 32'b00010);
        check("mid_rst_addr_data", 32'({pm_addr_o, pm_data_o}), 32'd0);
        @(negedge clk_i);
        rst_i = 1'b1;
        @(negedge clk_i);
        check("mid_rst_ready", 32'(rx_ready_o), 32'd1);
        wlog.delete();
        send(8'hA5); send(8'h01); send(8'h07); send(8'h07);
        check("post_rst_nwrites", 32'(wlog.size()), 32'd1);
        check_log("post_rst_w0", 0, 5'd0, 8'h07);
        check("post_rst_status", 32'({busy_o, done_o, err_o, cpu_rst_o}), 32'b0100);

        check("we_single_cycle", 32'(dbl_we), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
